// File: rtl/note_player.sv
// Note consumer: requests notes from the pattern sequencer, plays each for its
// length in frame ticks, gates the voice, and flags end of song on a response timeout.
module note_player #(
  parameter int TICKS_PER_STEP = 4,
  parameter int GAP_TICKS      = 1,
  parameter int RESP_TIMEOUT   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_tick,
  output logic       o_note_stb,
  input  logic       i_note_valid,
  input  logic [5:0] i_note_pitch,
  input  logic [4:0] i_note_len,
  input  logic [3:0] i_note_instrument,
  output logic       o_gate,
  output logic [5:0] o_pitch,
  output logic [3:0] o_instrument,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_WAIT    = 3'd2,
    S_PLAY    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [9:0] STEP_W = 10'(TICKS_PER_STEP);
  localparam logic [9:0] GAP_W  = 10'(GAP_TICKS);
  localparam logic [7:0] RESP_W = 8'(RESP_TIMEOUT);

  state_t     state_q, state_d;
  logic [9:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] pitch_q, pitch_d;
  logic [3:0] instr_q, instr_d;
  logic       stb_q, gate_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    pitch_d = pitch_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (i_note_valid) begin
          pitch_d = i_note_pitch;
          instr_d = i_note_instrument;
          rem_d   = ({5'd0, i_note_len} + 10'd1) * STEP_W;
          state_d = S_PLAY;
        end else if (cnt_q == RESP_W) begin
          state_d = S_DONE;
        end
      end
      S_PLAY: begin
        // Remaining == 0 holds PLAY for one more cycle after the final tick,
        // so the next strobe lands two cycles after that tick.
        if (rem_q == 10'd0) begin
          state_d = i_enable ? S_REQUEST : S_IDLE;
        end else if (i_tick) begin
          rem_d = rem_q - 10'd1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      rem_q   <= 10'd0;
      cnt_q   <= 8'd0;
      pitch_q <= 6'd0;
      instr_q <= 4'd0;
      stb_q   <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      pitch_q <= pitch_d;
      instr_q <= instr_d;
      // Outputs are decoded from the next state so they line up with state_q.
      stb_q   <= (state_d == S_REQUEST);
      gate_q  <= (state_d == S_PLAY) && (pitch_d != 6'd0) && (rem_d > GAP_W);
      busy_q  <= (state_d == S_REQUEST) || (state_d == S_WAIT) || (state_d == S_PLAY);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign o_note_stb   = stb_q;
  assign o_gate       = gate_q;
  assign o_pitch      = pitch_q;
  assign o_instrument = instr_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_state      = state_q;

endmodule
